msg_collector: RTL and testbench
================================

// Module: msg_collector
// PURPOSE
//  One instance per source channel, upstream of the FX2 slave-FIFO read/write engine. Collects
//  16-bit words from the channel deserializer into a show-ahead buffer and frames them into
//  messages. Commits a message (GOT_FULL_MSG, MSG_LEN) for the engine, which pops words with
//  RD_REQ and acknowledges with MSG_SENT. Collection of the next message continues while the
//  committed one is drained.
// PARAMETERS
//  MAX_LEN      64    words per message, 1..255; a message is closed when it reaches this
//  ADDR_W       8     buffer address width; depth = 2**ADDR_W, must be >= 2*MAX_LEN
//  TIMEOUT_CYC  1000  idle cycles that close a partial message (only with MSG_COLLECTOR_TIMEOUT_EN)
// PORTS
//  CLK           in   1       clock
//  RST           in   1       reset, asynchronous, active-low
//  DIN           in   16      word from deserializer
//  DIN_VALID     in   1       DIN valid this cycle, 1-cycle strobe per word
//  RD_REQ        in   1       pop head word; Q must be sampled in the same cycle
//  MSG_SENT      in   1       engine done; rising edge acknowledges the committed message
//  Q             out  16      head word of buffer (show-ahead); 0 when empty
//  GOT_FULL_MSG  out  1       a committed message is waiting
//  MSG_LEN       out  8       length of committed message; valid while GOT_FULL_MSG=1
//  OVERFLOW      out  1       sticky: an incoming word was dropped
//  LEN_ERR       out  1       sticky: pop count at acknowledge != MSG_LEN, or pop on empty
// BEHAVIOUR
//  Reset: all outputs 0, buffer empty, pend_cnt=0, idle_cnt=0, FSM=S_EMPTY, MSG_SENT edge reg=0.
//  Write: DIN_VALID and buffer not full and pend_cnt<MAX_LEN -> push, pend_cnt+1, idle_cnt=0.
//   Any other DIN_VALID word is dropped and OVERFLOW is set to 1.
//  Read: RD_REQ and GOT_FULL_MSG and buffer not empty -> pop, pop_cnt+1. Q updates the
//   next cycle. RD_REQ with GOT_FULL_MSG=0 is ignored. RD_REQ on empty buffer sets LEN_ERR.
//  Commit rule: pend_cnt==MAX_LEN, or (timeout enabled) pend_cnt>0 and idle_cnt==TIMEOUT_CYC-1.
//   Zero-length messages are never committed.
//  FSM S_EMPTY: on commit rule -> MSG_LEN<=pend_cnt, GOT_FULL_MSG<=1, pop_cnt<=0, -> S_READY.
//   A word accepted in the commit cycle starts the next message (pend_cnt<=1).
//  FSM S_READY: hold MSG_LEN. On rising edge of MSG_SENT (registered detect, 1 cycle) ->
//   LEN_ERR|=(pop_cnt!=MSG_LEN), GOT_FULL_MSG<=0, -> S_EMPTY. A pending commit
//   rule fires no earlier than the cycle after return to S_EMPTY. Gap >= 1 cycle with
//   GOT_FULL_MSG=0.
//  While in S_READY, pend_cnt saturates at MAX_LEN; further words are dropped (OVERFLOW).
//  idle_cnt increments while pend_cnt>0 and no word is accepted, saturates at TIMEOUT_CYC-1.
//   It holds during S_READY, so the commit fires immediately on return to S_EMPTY.
//  Simultaneous push and pop in one cycle: both take effect; occupancy unchanged.
//  MSG_LEN is 8 bits; MAX_LEN<=255 guarantees no truncation.
//  Reset mid-message discards the buffer contents and both counters. Sticky flags clear only on reset.
// CONFIGURATION
//  MSG_COLLECTOR_TIMEOUT_EN defined: idle timeout closes partial messages (rule above).
//  Not defined: idle_cnt logic is absent. Only pend_cnt==MAX_LEN commits, and partial data
//   waits indefinitely. TIMEOUT_CYC is unused.
// STRUCTURE
//  Shared package msg_pkg: FSM state encoding (S_EMPTY, S_READY), word width 16,
//   length width 8, PREFIX constant 16'h4444 shared with the slave-FIFO engine.
//  Sub-module msg_fifo: synchronous show-ahead FIFO, 16 bits x 2**ADDR_W. Ports: push, pop,
//   din, q, full, empty, level. msg_collector holds the framing FSM, counters and flags.
// TESTING
//  1 MAX_LEN=4: 4 words 16'h0001..0004 -> GOT_FULL_MSG=1, MSG_LEN=4. 4 pops give
//    Q=0001..0004. MSG_SENT pulse -> GOT_FULL_MSG=0 next cycle, LEN_ERR=0.
//  2 Timeout enabled, TIMEOUT_CYC=10: 3 words then idle -> commit 10 cycles after last word,
//    MSG_LEN=3. Without macro: no commit after 1000 idle cycles.
//  3 MAX_LEN=4, S_READY: 6 more words -> 4 accepted, 2 dropped, OVERFLOW=1. After MSG_SENT,
//    second message committed with MSG_LEN=4 and contents of first 4 new words.
//  4 Word arriving in the commit cycle -> appears as first word of the next message.
//    MSG_LEN of the first message is unaffected.
//  5 Acknowledge after only 2 of 4 pops -> LEN_ERR=1. RD_REQ with GOT_FULL_MSG=0 -> no pop,
//    Q unchanged.
//  6 RST low mid-collection (2 words buffered) -> all outputs 0. Next 4 words form a clean
//    MSG_LEN=4 message.

Source files
------------

// File: rtl/msg_pkg.sv
// ---------------------------------------------------------------------------
// msg_pkg
// Shared definitions for the message collector and the FX2 slave-FIFO engine:
//   - WORD_W  : data word width (16)
//   - LEN_W   : message length field width (8)
//   - PREFIX  : message prefix word shared with the slave-FIFO engine
//   - state_t : framing FSM state encoding (S_EMPTY, S_READY)
// ---------------------------------------------------------------------------
package msg_pkg;

    localparam int WORD_W = 16;
    localparam int LEN_W  = 8;

    localparam logic [WORD_W-1:0] PREFIX = 16'h4444;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_READY = 1'b1
    } state_t;

endpackage

// File: rtl/msg_collector_if.sv
// ---------------------------------------------------------------------------
// msg_collector_if
// Bundles the channel-side and engine-side signals of one msg_collector.
//   master : deserializer + slave-FIFO engine side (drives DIN, DIN_VALID,
//            RD_REQ, MSG_SENT; observes Q and status)
//   slave  : the collector itself
// Signals:
//   DIN/DIN_VALID  incoming word and its 1-cycle strobe
//   RD_REQ         pop head word (Q sampled in the same cycle)
//   MSG_SENT       engine done, rising edge acknowledges the committed message
//   Q              show-ahead head word, 0 when empty
//   GOT_FULL_MSG   committed message waiting
//   MSG_LEN        committed message length
//   OVERFLOW       sticky, an incoming word was dropped
//   LEN_ERR        sticky, pop count mismatch at acknowledge or pop on empty
// ---------------------------------------------------------------------------
interface msg_collector_if;
    import msg_pkg::*;

    logic [WORD_W-1:0] DIN;
    logic              DIN_VALID;
    logic              RD_REQ;
    logic              MSG_SENT;
    logic [WORD_W-1:0] Q;
    logic              GOT_FULL_MSG;
    logic [LEN_W-1:0]  MSG_LEN;
    logic              OVERFLOW;
    logic              LEN_ERR;

    modport master (
        output DIN, DIN_VALID, RD_REQ, MSG_SENT,
        input  Q, GOT_FULL_MSG, MSG_LEN, OVERFLOW, LEN_ERR
    );

    modport slave (
        input  DIN, DIN_VALID, RD_REQ, MSG_SENT,
        output Q, GOT_FULL_MSG, MSG_LEN, OVERFLOW, LEN_ERR
    );

endinterface

// File: rtl/msg_fifo.sv
// ---------------------------------------------------------------------------
// msg_fifo
// Synchronous show-ahead FIFO, WORD_W bits x 2**ADDR_W entries.
// Ports:
//   CLK, RST   clock, asynchronous active-low reset
//   push, din  write request and data (ignored when full)
//   pop        read request (ignored when empty)
//   q          head word, valid without a pop; 0 when empty
//   full       all entries occupied
//   empty      no entries occupied
//   level      current occupancy, 0..2**ADDR_W
// ---------------------------------------------------------------------------
module msg_fifo
    import msg_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] q,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Occupancy never exceeds 2**ADDR_W, so the MSB alone marks full.
    assign full  = count[ADDR_W];
    assign empty = (count == '0);
    assign level = count;
    assign q     = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/msg_collector.sv
// ---------------------------------------------------------------------------
// msg_collector
// Collects words from one channel deserializer into a show-ahead buffer and
// frames them into messages for the FX2 slave-FIFO engine. A message is
// committed when it reaches MAX_LEN words (or, with the idle timeout, after
// TIMEOUT_CYC idle cycles). Collection of the next message continues while
// the committed one is drained.
// Parameters:
//   MAX_LEN      words per message, 1..255
//   ADDR_W       buffer address width, 2**ADDR_W >= 2*MAX_LEN
//   TIMEOUT_CYC  idle cycles that close a partial message
// Ports:
//   CLK   clock
//   RST   asynchronous, active-low reset
//   bus   msg_collector_if.slave (DIN, DIN_VALID, RD_REQ, MSG_SENT, Q,
//         GOT_FULL_MSG, MSG_LEN, OVERFLOW, LEN_ERR)
// Configuration macro:
//   MSG_COLLECTOR_TIMEOUT_EN  defined: idle timeout closes partial messages.
//                             undefined: only full messages commit and
//                             TIMEOUT_CYC is unused.
// ---------------------------------------------------------------------------
module msg_collector
    import msg_pkg::*;
#(
    parameter int MAX_LEN     = 64,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic            CLK,
    input  logic            RST,
    msg_collector_if.slave  bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t            state;
    logic [LEN_W-1:0]  pend_cnt;
    logic [LEN_W-1:0]  pop_cnt;
    logic [LEN_W-1:0]  msg_len;
    logic              got_full_msg;
    logic              overflow;
    logic              len_err;
    logic              sent_q;

    logic [WORD_W-1:0] fifo_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_level;

    logic              idle_hit;
    logic              commit_rule;
    logic              commit_now;
    logic              accept;
    logic              pop_req;
    logic              pop_taken;
    logic              sent_rise;

    assign commit_rule = (pend_cnt == MAX_LEN_L) || idle_hit;
    assign commit_now  = (state == S_EMPTY) && commit_rule;

    // In the commit cycle the pending count restarts, so a word arriving then
    // is accepted as the first word of the next message.
    assign accept    = bus.DIN_VALID && !fifo_full &&
                       ((pend_cnt < MAX_LEN_L) || commit_now);
    assign pop_req   = bus.RD_REQ && got_full_msg;
    assign pop_taken = pop_req && (fifo_level != '0);
    assign sent_rise = bus.MSG_SENT && !sent_q;

    msg_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (accept),
        .pop   (pop_req),
        .din   (bus.DIN),
        .q     (fifo_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef MSG_COLLECTOR_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Keeps counting (saturating) while a message is held in S_READY, so a
    // timed-out partial message commits as soon as the FSM returns.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idle_cnt <= '0;
        end else if (accept || commit_now) begin
            idle_cnt <= '0;
        end else if ((pend_cnt != '0) && (idle_cnt != IDLE_MAX)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign idle_hit = (pend_cnt != '0) && (idle_cnt == IDLE_MAX);
`else
    assign idle_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= S_EMPTY;
            pend_cnt     <= '0;
            pop_cnt      <= '0;
            msg_len      <= '0;
            got_full_msg <= 1'b0;
            overflow     <= 1'b0;
            len_err      <= 1'b0;
            sent_q       <= 1'b0;
        end else begin
            sent_q <= bus.MSG_SENT;

            if (bus.DIN_VALID && !accept) overflow <= 1'b1;
            if (pop_req && fifo_empty)    len_err  <= 1'b1;
            if (pop_taken)                pop_cnt  <= pop_cnt + 1'b1;

            case (state)
                S_EMPTY: begin
                    if (commit_rule) begin
                        msg_len      <= pend_cnt;
                        got_full_msg <= 1'b1;
                        pop_cnt      <= '0;
                        pend_cnt     <= accept ? LEN_W'(1) : '0;
                        state        <= S_READY;
                    end else if (accept) begin
                        pend_cnt <= pend_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (accept) pend_cnt <= pend_cnt + 1'b1;
                    if (sent_rise) begin
                        if (pop_cnt != msg_len) len_err <= 1'b1;
                        got_full_msg <= 1'b0;
                        state        <= S_EMPTY;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign bus.Q            = fifo_q;
    assign bus.GOT_FULL_MSG = got_full_msg;
    assign bus.MSG_LEN      = msg_len;
    assign bus.OVERFLOW     = overflow;
    assign bus.LEN_ERR      = len_err;

endmodule

// File: tb/tb_msg_collector.sv
// ---------------------------------------------------------------------------
// tb_msg_collector
// Self-checking bench for msg_collector with MAX_LEN=4, ADDR_W=3,
// TIMEOUT_CYC=10. A vector table covers a basic collect/drain/acknowledge
// message; hand-written sequences cover saturation and overflow, a word in
// the commit cycle, short acknowledge, reset mid-collection and the idle
// timeout (behaviour depends on MSG_COLLECTOR_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_msg_collector;

    localparam int MAX_LEN     = 4;
    localparam int ADDR_W      = 3;
    localparam int TIMEOUT_CYC = 10;

    logic CLK;
    logic RST;

    int tests_run = 0;
    int tests_failed = 0;

    msg_collector_if bus ();

    msg_collector #(
        .MAX_LEN     (MAX_LEN),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        dv;
        logic [15:0] din;
        logic        rd;
        logic        sent;
        logic [15:0] q;
        logic        got;
        logic [7:0]  len;
        logic        ovf;
        logic        lerr;
    } vec_t;

    vec_t vecs [11];

    // Drives one cycle of inputs, waits for the edge, then settles 1 time unit.
    task automatic apply_stimulus(input logic dv, input logic [15:0] din,
                                  input logic rd, input logic sent);
        bus.DIN_VALID = dv;
        bus.DIN       = din;
        bus.RD_REQ    = rd;
        bus.MSG_SENT  = sent;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] q,
                             input logic got, input logic [7:0] len,
                             input logic ovf, input logic lerr);
        check_output({name, "_q"},    bus.Q,            q);
        check_output({name, "_got"},  bus.GOT_FULL_MSG, got);
        check_output({name, "_len"},  bus.MSG_LEN,      len);
        check_output({name, "_ovf"},  bus.OVERFLOW,     ovf);
        check_output({name, "_lerr"}, bus.LEN_ERR,      lerr);
    endtask

    task automatic push_word(input logic [15:0] w);
        apply_stimulus(1'b1, w, 1'b0, 1'b0);
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    // Head word is checked in the cycle it is popped.
    task automatic pop_expect(input string name, input logic [15:0] exp);
        check_output(name, bus.Q, exp);
        apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic ack_msg(input string name);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1);
        check_output({name, "_got_clear"}, bus.GOT_FULL_MSG, 1'b0);
        idle_cycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // dv din rd sent | q got len ovf lerr
        vecs[0]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0001, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0001, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0001, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 8'd4, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 8'd4, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 1'b1, 8'd4, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b1, 8'd4, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 8'd4, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 8'd4, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd4, 1'b0, 1'b0};

        RST           = 1'b0;
        bus.DIN       = 16'h0;
        bus.DIN_VALID = 1'b0;
        bus.RD_REQ    = 1'b0;
        bus.MSG_SENT  = 1'b0;
        #12;
        check_all("reset", 16'h0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;

        // Basic message: collect 4, drain 4, acknowledge.
        $display("[TB] basic message vectors");
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].dv, vecs[i].din, vecs[i].rd, vecs[i].sent);
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].got,
                      vecs[i].len, vecs[i].ovf, vecs[i].lerr);
        end

        // Saturation in S_READY: 6 words, 2 dropped, second message intact.
        $display("[TB] saturation and overflow");
        for (int i = 1; i <= 4; i++) push_word(16'hA000 + 16'(i));
        idle_cycle();
        check_output("sat_commit_got", bus.GOT_FULL_MSG, 1'b1);
        check_output("sat_commit_len", bus.MSG_LEN, 8'd4);
        for (int i = 1; i <= 6; i++) push_word(16'hB000 + 16'(i));
        check_output("sat_ovf", bus.OVERFLOW, 1'b1);
        check_output("sat_len_held", bus.MSG_LEN, 8'd4);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("sat_popA%0d", i), 16'hA000 + 16'(i));
        ack_msg("sat_ack1");
        check_output("sat_msg2_got", bus.GOT_FULL_MSG, 1'b1);
        check_output("sat_msg2_len", bus.MSG_LEN, 8'd4);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("sat_popB%0d", i), 16'hB000 + 16'(i));
        check_output("sat_drained_q", bus.Q, 16'h0);
        ack_msg("sat_ack2");
        check_output("sat_lerr", bus.LEN_ERR, 1'b0);

        // Word arriving in the commit cycle opens the next message.
        $display("[TB] word in commit cycle");
        for (int i = 1; i <= 4; i++) push_word(16'hC000 + 16'(i));
        push_word(16'hC005);
        check_output("cc_got", bus.GOT_FULL_MSG, 1'b1);
        check_output("cc_len", bus.MSG_LEN, 8'd4);
        for (int i = 6; i <= 8; i++) push_word(16'hC000 + 16'(i));
        check_output("cc_len_held", bus.MSG_LEN, 8'd4);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("cc_pop%0d", i), 16'hC000 + 16'(i));
        ack_msg("cc_ack1");
        check_output("cc_msg2_got", bus.GOT_FULL_MSG, 1'b1);
        check_output("cc_msg2_len", bus.MSG_LEN, 8'd4);
        for (int i = 5; i <= 8; i++) pop_expect($sformatf("cc_pop%0d", i), 16'hC000 + 16'(i));
        ack_msg("cc_ack2");
        check_output("cc_lerr", bus.LEN_ERR, 1'b0);

        // Short acknowledge, then RD_REQ without a committed message.
        $display("[TB] short acknowledge");
        for (int i = 1; i <= 4; i++) push_word(16'hD000 + 16'(i));
        idle_cycle();
        check_output("short_got", bus.GOT_FULL_MSG, 1'b1);
        pop_expect("short_pop1", 16'hD001);
        pop_expect("short_pop2", 16'hD002);
        ack_msg("short_ack");
        check_output("short_lerr", bus.LEN_ERR, 1'b1);
        apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
        check_output("ignored_rd_q1", bus.Q, 16'hD003);
        apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
        check_output("ignored_rd_q2", bus.Q, 16'hD003);
        check_output("ignored_rd_got", bus.GOT_FULL_MSG, 1'b0);

        // Reset mid-collection, then a clean message.
        $display("[TB] reset mid-collection");
        push_word(16'hE001);
        push_word(16'hE002);
        bus.DIN_VALID = 1'b0;
        bus.RD_REQ    = 1'b0;
        RST = 1'b0;
        #2;
        check_all("midrst", 16'h0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(16'hF000 + 16'(i));
        idle_cycle();
        check_all("postrst", 16'hF001, 1'b1, 8'd4, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("postrst_pop%0d", i), 16'hF000 + 16'(i));
        ack_msg("postrst_ack");
        check_output("postrst_lerr", bus.LEN_ERR, 1'b0);

        // Idle timeout on a 3-word partial message.
        $display("[TB] idle timeout");
        for (int i = 1; i <= 3; i++) push_word(16'h6000 + 16'(i));
`ifdef MSG_COLLECTOR_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) idle_cycle();
        check_output("to_not_yet", bus.GOT_FULL_MSG, 1'b0);
        idle_cycle();
        check_output("to_got", bus.GOT_FULL_MSG, 1'b1);
        check_output("to_len", bus.MSG_LEN, 8'd3);
        for (int i = 1; i <= 3; i++) pop_expect($sformatf("to_pop%0d", i), 16'h6000 + 16'(i));
        ack_msg("to_ack");
        check_output("to_lerr", bus.LEN_ERR, 1'b0);
`else
        for (int i = 0; i < 3 * TIMEOUT_CYC; i++) idle_cycle();
        check_output("nto_got", bus.GOT_FULL_MSG, 1'b0);
        check_output("nto_q", bus.Q, 16'h6001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
